bidcount_monitor: RTL and testbench

Passive checker on the receiving end of the bidirectional counter's `count` bus. It samples the count stream and infers the counting direction, declaring lock after a run of consistent steps. In lock it counts wrap-arounds and reports direction reversals; any illegal step raises an error and forces re-acquisition. It sits beside the counter in the RTL2GDS flow as a self-check / observability block; it drives nothing back into the counter.

---
 rtl/bidcount_monitor.sv | 154 +++++++++++++++
 tb/tb_bidcount_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bidcount_monitor.sv
// bidcount_monitor
// Passive checker for a bidirectional counter's count bus. Infers the
// counting direction from successive samples, locks after LOCK_LEN
// consistent steps, then counts wraps, flags reversals and flags illegal
// steps (stall/jump), dropping back to acquisition on an error.
//
// Ports:
//   clk       - clock, all state on rising edge
//   reset_n   - asynchronous active-low reset
//   sample    - count_in is accepted this cycle; state holds when low
//   count_in  - observed counter value (WIDTH bits)
//   locked    - direction established
//   dir       - 1 = up, 0 = down (valid while locked)
//   rev       - one-cycle pulse on an accepted reversal while locked
//   err       - one-cycle pulse on an illegal step while locked
//   err_cnt   - saturating error count
//   wrap_cnt  - wrap count, modulo 256
module bidcount_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             dir,
  output logic             rev,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic [7:0]       wrap_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [3:0]       LOCK = 4'(LOCK_LEN);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       run_q, run_d;
  logic             run_dir_q, run_dir_d;
  logic             dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             rev_q, rev_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [7:0]       wrap_cnt_q, wrap_cnt_d;

  logic [WIDTH-1:0] delta;
  logic             is_up, is_dn, is_step, crosses;
  logic [3:0]       run_nxt;

  assign delta   = count_in - prev_q;
  assign is_up   = (delta == ONE);
  assign is_dn   = (delta == MAXV);
  assign is_step = is_up | is_dn;
  // Boundary crossing in either direction, regardless of locked dir.
  assign crosses = (is_up && prev_q == MAXV) || (is_dn && prev_q == '0);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    run_d      = run_q;
    run_dir_d  = run_dir_q;
    dir_d      = dir_q;
    locked_d   = locked_q;
    rev_d      = 1'b0;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    run_nxt    = 4'd0;

    if (sample) begin
      prev_d = count_in;
      case (state_q)
        S_IDLE: begin
          // First sample only seeds prev; there is no step to judge yet.
          state_d = S_ACQ;
          run_d   = 4'd0;
        end
        S_ACQ: begin
          if (is_step) begin
            // run==0 marks "no direction yet" (fresh entry or after stall/jump).
            if (run_q == 4'd0 || run_dir_q != is_up) run_nxt = 4'd1;
            else                                    run_nxt = run_q + 4'd1;
            run_d     = run_nxt;
            run_dir_d = is_up;
            if (run_nxt == LOCK) begin
              state_d  = S_LOCKED;
              dir_d    = is_up;
              locked_d = 1'b1;
              run_d    = 4'd0;
            end
          end else begin
            // Irregular steps during acquisition are expected, not errors.
            run_d = 4'd0;
          end
        end
        S_LOCKED: begin
          if (is_step) begin
            if (is_up != dir_q) begin
              dir_d = is_up;
              rev_d = 1'b1;
            end
            if (crosses) wrap_cnt_d = wrap_cnt_q + 8'd1;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = S_ACQ;
            run_d    = 4'd0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      prev_q     <= '0;
      run_q      <= 4'd0;
      run_dir_q  <= 1'b0;
      dir_q      <= 1'b0;
      locked_q   <= 1'b0;
      rev_q      <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
      wrap_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      run_dir_q  <= run_dir_d;
      dir_q      <= dir_d;
      locked_q   <= locked_d;
      rev_q      <= rev_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign locked   = locked_q;
  assign dir      = dir_q;
  assign rev      = rev_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_bidcount_monitor.sv
// Testbench for bidcount_monitor (WIDTH=4, LOCK_LEN=3). A table of
// {sample, count_in, expected outputs} rows is applied in order; each row's
// expectation goes into a scoreboard queue and is compared one edge later.
// Hand-written sequences cover stall, saturation and asynchronous reset.
module tb_bidcount_monitor;

  logic       clk, reset_n, sample;
  logic [3:0] count_in;
  logic       locked, dir, rev, err;
  logic [7:0] err_cnt, wrap_cnt;

  bidcount_monitor #(.WIDTH(4), .LOCK_LEN(3)) dut (
    .clk(clk), .reset_n(reset_n), .sample(sample), .count_in(count_in),
    .locked(locked), .dir(dir), .rev(rev), .err(err),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       lk, dr, rv, er;
    logic [7:0] ec, wc;
  } exp_t;

  typedef struct {
    logic       smp;
    logic [3:0] cin;
    exp_t       e;
    string      nm;
  } vec_t;

  typedef struct {
    exp_t  e;
    string nm;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic exp_t mk(logic lk, logic dr, logic rv, logic er, int ec, int wc);
    exp_t e;
    e.lk = lk; e.dr = dr; e.rv = rv; e.er = er;
    e.ec = 8'(ec); e.wc = 8'(wc);
    return e;
  endfunction

  function automatic void add(logic s, int c, exp_t e, string nm);
    vec_t v;
    v.smp = s; v.cin = 4'(c); v.e = e; v.nm = nm;
    tbl.push_back(v);
  endfunction

  task automatic compare(string nm, exp_t want);
    exp_t got;
    got = {locked, dir, rev, err, err_cnt, wrap_cnt};
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got lk=%0b dir=%0b rev=%0b err=%0b ec=%0d wc=%0d, want lk=%0b dir=%0b rev=%0b err=%0b ec=%0d wc=%0d",
                  nm, got.lk, got.dr, got.rv, got.er, got.ec, got.wc,
                  want.lk, want.dr, want.rv, want.er, want.ec, want.wc);
  endtask

  task automatic apply(logic s, logic [3:0] c, exp_t e, string nm);
    sb_t r;
    @(negedge clk);
    sample   = s;
    count_in = c;
    r.e = e; r.nm = nm;
    sbq.push_back(r);
  endtask

  task automatic drain();
    int k;
    @(negedge clk);
    sample = 1'b0;
    k = 0;
    while (sbq.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() > 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d entries left, want 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Scoreboard checker: one expectation per accepted edge.
  initial begin
    sb_t r;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        r = sbq.pop_front();
        compare(r.nm, r.e);
      end
    end
  end

  initial begin
    logic [3:0] a;
    int         ec;
    logic       d;

    reset_n = 1'b0; sample = 1'b0; count_in = 4'd0;

    // Main table.
    add(0, 7,  mk(0,0,0,0,0,0), "gate_idle");
    add(0, 2,  mk(0,0,0,0,0,0), "gate_idle2");
    add(1, 5,  mk(0,0,0,0,0,0), "idle_first");
    add(1, 6,  mk(0,0,0,0,0,0), "acq1");
    add(1, 7,  mk(0,0,0,0,0,0), "acq2");
    add(1, 8,  mk(1,1,0,0,0,0), "lock_up");
    add(1, 9,  mk(1,1,0,0,0,0), "up9");
    add(1, 8,  mk(1,0,1,0,0,0), "rev_down");
    add(1, 7,  mk(1,0,0,0,0,0), "down7");
    add(1, 8,  mk(1,1,1,0,0,0), "rev_up");
    for (int v = 9; v <= 15; v++) add(1, v, mk(1,1,0,0,0,0), "up_run");
    add(1, 0,  mk(1,1,0,0,0,1), "wrap_up");
    add(1, 1,  mk(1,1,0,0,0,1), "up1");
    add(1, 2,  mk(1,1,0,0,0,1), "up2");
    add(1, 1,  mk(1,0,1,0,0,1), "rev_after_2");
    add(1, 0,  mk(1,0,0,0,0,1), "down0");
    add(1, 15, mk(1,0,0,0,0,2), "wrap_down");
    add(1, 0,  mk(1,1,1,0,0,3), "rev_wrap");
    add(1, 1,  mk(1,1,0,0,0,3), "up1b");
    add(1, 2,  mk(1,1,0,0,0,3), "up2b");
    add(1, 3,  mk(1,1,0,0,0,3), "up3b");
    add(1, 7,  mk(0,1,0,1,1,3), "jump_err");
    add(1, 8,  mk(0,1,0,0,1,3), "reacq1");
    add(1, 9,  mk(0,1,0,0,1,3), "reacq2");
    add(1, 10, mk(1,1,0,0,1,3), "relock");
    add(0, 3,  mk(1,1,0,0,1,3), "gap_hold");
    add(1, 11, mk(1,1,0,0,1,3), "gap_no_err");
    add(1, 10, mk(1,0,1,0,1,3), "rev_pre_gap");
    add(0, 4,  mk(1,0,0,0,1,3), "rev_gated");
    add(1, 10, mk(0,0,0,1,2,3), "stall_err");
    add(1, 10, mk(0,0,0,0,2,3), "acq_stall");
    add(1, 2,  mk(0,0,0,0,2,3), "acq_jump");
    add(1, 3,  mk(0,0,0,0,2,3), "acq_up");
    add(1, 2,  mk(0,0,0,0,2,3), "acq_turn");
    add(1, 1,  mk(0,0,0,0,2,3), "acq_dn2");
    add(1, 0,  mk(1,0,0,0,2,3), "lock_down");
    add(1, 15, mk(1,0,0,0,2,4), "wrap_down2");

    // Reset state, held through a few edges.
    repeat (2) @(negedge clk);
    compare("reset_state", mk(0,0,0,0,0,0));
    reset_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i].smp, tbl[i].cin, tbl[i].e, tbl[i].nm);

    // Stall while locked: only the first repeat is an error.
    apply(1, 4'd15, mk(0,0,0,1,3,4), "stall_first");
    for (int i = 1; i < 300; i++) apply(1, 4'd15, mk(0,0,0,0,3,4), "stall_rep");

    // Lock/jump cycles: err_cnt saturates at 255, wrap_cnt untouched.
    a = 4'd15; ec = 3; d = 1'b0;
    for (int k = 0; k < 300; k++) begin
      apply(1, a + 4'd1, mk(0,d,0,0,ec,4), "sat_acq1");
      apply(1, a + 4'd2, mk(0,d,0,0,ec,4), "sat_acq2");
      apply(1, a + 4'd3, mk(1,1,0,0,ec,4), "sat_lock");
      d  = 1'b1;
      ec = (ec < 255) ? ec + 1 : 255;
      apply(1, a + 4'd8, mk(0,1,0,1,ec,4), "sat_jump");
      a  = a + 4'd8;
    end
    apply(1, a + 4'd1, mk(0,1,0,0,255,4), "pre_reset");
    drain();

    // Asynchronous reset mid-stream: outputs clear without a clock edge.
    #2 reset_n = 1'b0;
    #1 compare("async_reset", mk(0,0,0,0,0,0));
    @(negedge clk);
    reset_n = 1'b1;
    apply(1, 4'd5, mk(0,0,0,0,0,0), "post_rst_idle");
    apply(1, 4'd9, mk(0,0,0,0,0,0), "post_rst_jump");
    apply(1, 4'd10, mk(0,0,0,0,0,0), "post_rst_acq");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
